// File: rtl/stream_rr_arbiter_pkg.sv
// Shared helpers for the round-robin stream arbiter.
// Index arithmetic here is modulo the requester count, not modulo 2^width.
package stream_rr_arbiter_pkg;

   function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/stream_rr_arbiter_rr_priority_encoder.sv
// Combinational round-robin priority encoder: first set request at or after
// prio_i, wrapping at p_width (non-power-of-two widths wrap correctly).
module RRPriorityEncoder
   import stream_rr_arbiter_pkg::*;
#(
   parameter int unsigned p_width = 4
) (
   input  logic [p_width-1:0]         req_i,
   input  logic [$clog2(p_width)-1:0] prio_i,
   output logic [p_width-1:0]         gnt_o,
   output logic [$clog2(p_width)-1:0] gnt_idx_o,
   output logic                       any_o
);

   localparam int unsigned IW = $clog2(p_width);

   int unsigned scan_idx;
   logic        found;

   always_comb begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      found     = 1'b0;
      scan_idx  = 32'(prio_i);
      for (int k = 0; k < p_width; k++) begin
         if (!found && req_i[IW'(scan_idx)]) begin
            found                 = 1'b1;
            gnt_o[IW'(scan_idx)]  = 1'b1;
            gnt_idx_o             = IW'(scan_idx);
         end
         scan_idx = wrap_inc(scan_idx, p_width);
      end
      any_o = found;
   end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter merging p_num_req valid/ready streams into one, with
// zero-latency forwarding and a grant lock held across back-pressure.
module stream_rr_arbiter
   import stream_rr_arbiter_pkg::*;
#(
   parameter type         t_msg     = logic [31:0],
   parameter int unsigned p_num_req = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  t_msg                         req_msg_i [p_num_req],
   input  logic [p_num_req-1:0]         req_val_i,
   output logic [p_num_req-1:0]         req_rdy_o,
   output t_msg                         gnt_msg_o,
   output logic                         gnt_val_o,
   input  logic                         gnt_rdy_i,
   output logic [$clog2(p_num_req)-1:0] gnt_id_o
);

   localparam int unsigned IDW = $clog2(p_num_req);

   logic [IDW-1:0]       prio_q, prio_d;
   logic [IDW-1:0]       lock_id_q, lock_id_d;
   logic                 locked_q, locked_d;
   logic [IDW-1:0]       arb_idx, grant_idx;
   logic [p_num_req-1:0] arb_onehot, lock_onehot, sel_onehot;
   logic                 arb_any, grant_act, xfer, stall;

   RRPriorityEncoder #(.p_width(p_num_req)) u_enc (
      .req_i     (req_val_i),
      .prio_i    (prio_q),
      .gnt_o     (arb_onehot),
      .gnt_idx_o (arb_idx),
      .any_o     (arb_any)
   );

   // While locked the grant ignores every other val, even if the owner drops its own.
   assign grant_idx  = locked_q ? lock_id_q : arb_idx;
   assign sel_onehot = locked_q ? lock_onehot : arb_onehot;
   assign grant_act  = !rst && (locked_q || arb_any);

   assign gnt_val_o = grant_act && req_val_i[grant_idx];
   assign gnt_msg_o = req_msg_i[grant_idx];
   assign gnt_id_o  = rst ? '0 : grant_idx;

   genvar gi;
   generate
      for (gi = 0; gi < p_num_req; gi++) begin : g_fanout
         assign lock_onehot[gi] = (lock_id_q == IDW'(gi));
         assign req_rdy_o[gi]   = grant_act && sel_onehot[gi] && gnt_rdy_i;
      end
   endgenerate

   assign xfer  = gnt_val_o && gnt_rdy_i;
   assign stall = gnt_val_o && !gnt_rdy_i;

   always_comb begin
      prio_d    = prio_q;
      locked_d  = locked_q;
      lock_id_d = lock_id_q;
      if (xfer) begin
         prio_d   = IDW'(wrap_inc(32'(grant_idx), p_num_req));
         locked_d = 1'b0;
      end else if (stall && !locked_q) begin
         locked_d  = 1'b1;
         lock_id_d = grant_idx;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prio_q    <= '0;
         locked_q  <= 1'b0;
         lock_id_q <= '0;
      end else begin
         prio_q    <= prio_d;
         locked_q  <= locked_d;
         lock_id_q <= lock_id_d;
      end
   end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Scoreboard bench for stream_rr_arbiter: a behavioural arbitration model
// queues expected per-cycle outputs and transfers; a negedge monitor checks them.
module tb_stream_rr_arbiter;

   localparam int N  = 4;
   localparam int N3 = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic [31:0]   req_msg [N];
   logic [N-1:0]  req_val;
   logic [N-1:0]  req_rdy;
   logic [31:0]   gnt_msg;
   logic          gnt_val;
   logic          gnt_rdy;
   logic [1:0]    gnt_id;

   logic [31:0]   msg3 [N3];
   logic [N3-1:0] val3;
   logic [N3-1:0] rdy3;
   logic [31:0]   gnt_msg3;
   logic          gnt_val3;
   logic          gnt_rdy3;
   logic [1:0]    gnt_id3;

   stream_rr_arbiter #(.t_msg(logic [31:0]), .p_num_req(N)) dut (
      .clk(clk), .rst(rst),
      .req_msg_i(req_msg), .req_val_i(req_val), .req_rdy_o(req_rdy),
      .gnt_msg_o(gnt_msg), .gnt_val_o(gnt_val), .gnt_rdy_i(gnt_rdy),
      .gnt_id_o(gnt_id)
   );

   stream_rr_arbiter #(.t_msg(logic [31:0]), .p_num_req(N3)) dut3 (
      .clk(clk), .rst(rst),
      .req_msg_i(msg3), .req_val_i(val3), .req_rdy_o(rdy3),
      .gnt_msg_o(gnt_msg3), .gnt_val_o(gnt_val3), .gnt_rdy_i(gnt_rdy3),
      .gnt_id_o(gnt_id3)
   );

   typedef struct {
      bit           rst;
      bit           val;
      int           id;
      logic [31:0]  msg;
      logic [N-1:0] rdy;
   } cyc_t;

   typedef struct {
      int          id;
      logic [31:0] msg;
   } xfer_t;

   cyc_t  cyc_q [$];
   xfer_t xfer_q [$];
   int    id_log [$];

   int vectors     = 0;
   int miscompares = 0;

   // Model state: next search start, held source (-1 = none), this cycle's transfer.
   int m_prio = 0;
   int m_hold = -1;
   int m_xfer = -1;

   logic [31:0] nxt_msg [N];
   int          wait_cnt [N];
   int          n3 = 0;

   task automatic check(input string name, input longint act, input longint exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: grant = held source if any, else first valid from m_prio upward mod N.
   task automatic model_cycle();
      cyc_t c;
      int   g;
      c.rst = rst; c.val = 1'b0; c.id = 0; c.msg = '0; c.rdy = '0;
      m_xfer = -1;
      if (rst) begin
         m_prio = 0;
         m_hold = -1;
      end else begin
         g = -1;
         if (m_hold >= 0) g = m_hold;
         else begin
            for (int k = 0; k < N; k++) begin
               if (g < 0 && req_val[(m_prio + k) % N]) g = (m_prio + k) % N;
            end
         end
         if (g >= 0) begin
            c.id     = g;
            c.val    = req_val[g];
            c.msg    = req_msg[g];
            c.rdy[g] = gnt_rdy;
            if (c.val && gnt_rdy) begin
               xfer_q.push_back('{id: g, msg: req_msg[g]});
               m_prio = (g + 1) % N;
               m_hold = -1;
               m_xfer = g;
            end else if (c.val) begin
               m_hold = g;
            end
         end
      end
      cyc_q.push_back(c);
   endtask

   task automatic apply(input bit r, input logic [N-1:0] v, input bit rd);
      @(posedge clk);
      #1;
      rst     = r;
      req_val = v;
      gnt_rdy = rd;
      for (int i = 0; i < N; i++) req_msg[i] = nxt_msg[i];
      model_cycle();
   endtask

   cyc_t  mc;
   xfer_t mx;

   always @(negedge clk) begin
      if (cyc_q.size() > 0) begin
         mc = cyc_q.pop_front();
         check("gnt_val", gnt_val, mc.val);
         check("req_rdy", req_rdy, mc.rdy);
         if (mc.rst || mc.val) check("gnt_id", gnt_id, mc.id);
         if (mc.val) check("gnt_msg", gnt_msg, mc.msg);
         if (gnt_val && gnt_rdy) begin
            if (xfer_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL xfer_extra: got id %0d msg %0h expected no transfer", gnt_id, gnt_msg);
            end else begin
               mx = xfer_q.pop_front();
               check("xfer_id", gnt_id, mx.id);
               check("xfer_msg", gnt_msg, mx.msg);
            end
            id_log.push_back(int'(gnt_id));
            for (int i = 0; i < N; i++) begin
               if (i == int'(gnt_id) || !req_val[i]) wait_cnt[i] = 0;
               else begin
                  wait_cnt[i]++;
                  vectors++;
                  if (wait_cnt[i] > N) begin
                     miscompares++;
                     $display("FAIL fairness: src %0d waited %0d transfers, limit %0d", i, wait_cnt[i], N);
                  end
               end
            end
         end
         if (rst) begin
            for (int i = 0; i < N; i++) wait_cnt[i] = 0;
            check("n3_rst_val", gnt_val3, 0);
            n3 = 0;
         end else if (n3 < 8) begin
            check("n3_val", gnt_val3, 1);
            check("n3_id", gnt_id3, n3 % N3);
            n3++;
         end
      end
   end

   logic [31:0] src_q [N][$];
   int          delay [N];
   bit          holding [N];
   bit          done;
   logic [N-1:0] v;

   initial begin
      rst = 1'b1; req_val = '0; gnt_rdy = 1'b0;
      for (int i = 0; i < N; i++) begin
         nxt_msg[i] = 32'h10 + 32'(i);
         req_msg[i] = nxt_msg[i];
         wait_cnt[i] = 0;
      end
      for (int i = 0; i < N3; i++) msg3[i] = 32'h300 + 32'(i);
      val3 = '1;
      gnt_rdy3 = 1'b1;

      apply(1, '0, 0);
      apply(1, '0, 0);

      // Single requester on index 2
      id_log.delete();
      nxt_msg[2] = 32'hA; apply(0, 4'b0100, 1);
      nxt_msg[2] = 32'hB; apply(0, 4'b0100, 1);
      apply(1, '0, 0);
      check("single_cnt", id_log.size(), 2);
      for (int k = 0; k < 2; k++) check("single_id", id_log[k], 2);

      // Round robin with all valid
      for (int i = 0; i < N; i++) nxt_msg[i] = 32'h10 + 32'(i);
      id_log.delete();
      repeat (6) apply(0, 4'b1111, 1);
      apply(1, '0, 0);
      check("rr_cnt", id_log.size(), 6);
      for (int k = 0; k < 6; k++) check("rr_order", id_log[k], k % N);

      // Back-pressure lock on req[1], req[0] joins during the stall
      nxt_msg[1] = 32'h55; nxt_msg[0] = 32'h77;
      id_log.delete();
      apply(0, 4'b0010, 0);
      apply(0, 4'b0011, 0);
      apply(0, 4'b0011, 0);
      apply(0, 4'b0011, 1);
      apply(0, 4'b0001, 1);
      apply(1, '0, 0);
      check("lock_cnt", id_log.size(), 2);
      check("lock_first", id_log[0], 1);
      check("lock_second", id_log[1], 0);

      // Reset while locked on req[3]
      nxt_msg[3] = 32'h33;
      id_log.delete();
      apply(0, 4'b1000, 0);
      apply(0, 4'b1000, 0);
      apply(1, 4'b1111, 1);
      apply(0, 4'b1111, 1);
      apply(1, '0, 0);
      check("rstlock_cnt", id_log.size(), 1);
      check("rstlock_first", id_log[0], 0);

      // Randomized sources with 0..3 idle cycles between messages
      for (int i = 0; i < N; i++) begin
         for (int s = 0; s < 25; s++) src_q[i].push_back((32'(i) << 24) | 32'(s));
         delay[i]   = $urandom_range(0, 3);
         holding[i] = 1'b0;
      end
      done = 1'b0;
      for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
         v = '0;
         for (int i = 0; i < N; i++) begin
            if (!holding[i]) begin
               if (delay[i] > 0) delay[i]--;
               else if (src_q[i].size() > 0) holding[i] = 1'b1;
            end
            if (holding[i]) begin
               v[i] = 1'b1;
               nxt_msg[i] = src_q[i][0];
            end else begin
               nxt_msg[i] = $urandom;
            end
         end
         apply(0, v, $urandom_range(0, 3) != 0);
         if (m_xfer >= 0) begin
            void'(src_q[m_xfer].pop_front());
            holding[m_xfer] = 1'b0;
            delay[m_xfer]   = $urandom_range(0, 3);
         end
         done = 1'b1;
         for (int i = 0; i < N; i++) if (holding[i] || src_q[i].size() > 0) done = 1'b0;
      end
      if (!done) begin
         vectors++;
         miscompares++;
         $display("FAIL random_timeout: got sources still pending expected all drained");
      end

      apply(0, '0, 1);
      apply(1, '0, 0);
      @(negedge clk);
      #1;
      check("leftover_xfers", xfer_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion expected finish before time limit");
      $fatal(1, "watchdog");
   end

endmodule
